// File: rtl/lfsr_checker.sv
// Shadow-model checker for the loadable LFSR counter: flags count mismatches,
// reports all-zero lock-up and measures the sequence period from the last load.
module lfsr_checker #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'hB8,
    parameter int              PW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             cen,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] count,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic             lockup,
    output logic [PW-1:0]    period,
    output logic             period_valid
);

    // state | meaning
    // IDLE  | one cycle after reset: seed the model from count, no compare
    // CHECK | compare count against the model every cycle, measure period
    typedef enum logic {IDLE, CHECK} state_t;

    localparam logic [PW-1:0] STEPS_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] model;
    logic [WIDTH-1:0] model_nxt;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] seed_nxt;
    logic             seed_vld;
    logic             seed_vld_nxt;
    logic [PW-1:0]    steps;
    logic [PW-1:0]    steps_nxt;
    logic             err_nxt;
    logic [7:0]       err_cnt_nxt;
    logic             lockup_nxt;
    logic [PW-1:0]    period_nxt;
    logic             period_valid_nxt;
    logic             mismatch;
    logic [WIDTH-1:0] resync;
    logic [WIDTH-1:0] advance;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ^(x & TAPS)};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            state_nxt = CHECK;
        end
    end

    always_comb begin
        model_nxt        = model;
        seed_nxt         = seed;
        seed_vld_nxt     = seed_vld;
        steps_nxt        = steps;
        err_nxt          = 1'b0;
        err_cnt_nxt      = err_cnt;
        period_nxt       = period;
        period_valid_nxt = 1'b0;
        lockup_nxt       = (state == CHECK) && (count == '0);
        mismatch         = (state == CHECK) && (count != model);
        resync           = load ? data : (cen ? lfsr_next(count) : count);
        advance          = load ? data : (cen ? lfsr_next(model) : model);

        if (state == IDLE) begin
            model_nxt = resync;
        end else begin
            if (mismatch) begin
                err_nxt      = 1'b1;
                model_nxt    = resync;
                seed_vld_nxt = 1'b0;
                if (err_cnt != 8'hFF) begin
                    err_cnt_nxt = err_cnt + 8'd1;
                end
            end else begin
                model_nxt = advance;
            end

            // A step that lands back on the seed closes one revolution.
            if (load) begin
                seed_nxt     = data;
                seed_vld_nxt = 1'b1;
                steps_nxt    = '0;
            end else if (cen && seed_vld && !mismatch && steps != STEPS_MAX) begin
                if (lfsr_next(model) == seed) begin
                    period_nxt       = steps + PW'(1);
                    period_valid_nxt = 1'b1;
                    steps_nxt        = '0;
                end else begin
                    steps_nxt = steps + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            model        <= '0;
            seed         <= '0;
            seed_vld     <= 1'b0;
            steps        <= '0;
            err          <= 1'b0;
            err_cnt      <= '0;
            lockup       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            model        <= model_nxt;
            seed         <= seed_nxt;
            seed_vld     <= seed_vld_nxt;
            steps        <= steps_nxt;
            err          <= err_nxt;
            err_cnt      <= err_cnt_nxt;
            lockup       <= lockup_nxt;
            period       <= period_nxt;
            period_valid <= period_valid_nxt;
        end
    end

endmodule
